// File: rtl/mem_io_responder_if.sv
// rtl/mem_io_responder_if.sv - CPU-side MAR/MDR request/response bundle for mem_io_responder
interface mem_io_responder_if;
    logic        Req;
    logic        WE;
    logic [15:0] Addr;
    logic [15:0] Data_from_CPU;
    logic [15:0] Data_to_CPU;
    logic        Ready;
    logic        Busy;

    modport master (
        output Req, WE, Addr, Data_from_CPU,
        input  Data_to_CPU, Ready, Busy
    );

    modport slave (
        input  Req, WE, Addr, Data_from_CPU,
        output Data_to_CPU, Ready, Busy
    );
endinterface

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - LC-3 memory responder: wait-stated RAM plus switch/hex I/O port
module mem_io_responder #(
    parameter int          DEPTH       = 256,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    mem_io_responder_if.slave    bus,
    input  logic [15:0]          Switches,
    output logic [15:0]          Hex_Out,
    output logic                 Overrun
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [15:0] lat_addr;
    logic [15:0] lat_data;
    logic [15:0] data_to_cpu;
    logic [15:0] mem [DEPTH];

    logic          commit;
    logic          op_we;
    logic [15:0]   op_addr;
    logic [15:0]   op_data;
    logic          op_io;
    logic [AW-1:0] op_idx;

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (bus.Req) next_state = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt <= 4'd1) next_state = S_RESP;
            S_RESP: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // With zero wait states the commit edge is the acceptance edge, so the
    // operation must come straight from the bus rather than the latches.
    always_comb begin
        commit  = (next_state == S_RESP) && (state != S_RESP);
        op_we   = (state == S_IDLE) ? bus.WE            : lat_we;
        op_addr = (state == S_IDLE) ? bus.Addr          : lat_addr;
        op_data = (state == S_IDLE) ? bus.Data_from_CPU : lat_data;
        op_io   = (op_addr == IO_ADDR);
        op_idx  = op_addr[AW-1:0];
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            lat_we      <= 1'b0;
            lat_addr    <= 16'h0000;
            lat_data    <= 16'h0000;
            data_to_cpu <= 16'h0000;
            Hex_Out     <= 16'h0000;
            Overrun     <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && bus.Req) begin
                lat_we   <= bus.WE;
                lat_addr <= bus.Addr;
                lat_data <= bus.Data_from_CPU;
                cnt      <= 4'(WAIT_STATES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state != S_IDLE && bus.Req) Overrun <= 1'b1;
            if (commit) begin
                if (!op_we)    data_to_cpu <= op_io ? Switches : mem[op_idx];
                else if (op_io) Hex_Out    <= op_data;
            end
        end
    end

    // RAM is never cleared; gating on Reset keeps a write from landing while reset is held.
    always_ff @(posedge Clk) begin
        if (commit && op_we && !op_io && Reset) mem[op_idx] <= op_data;
    end

    assign bus.Data_to_CPU = data_to_cpu;
    assign bus.Ready       = (state == S_RESP);
    assign bus.Busy        = (state != S_IDLE);
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the LC-3 CPU's MAR/MDR memory accesses.
- Accepts read and write requests from the CPU and services them from an internal word-addressed RAM after a fixed number of wait states.
- Maps one address to I/O: reads return the switches, writes go to the hex display register.
- Returns read data and a one-cycle Ready pulse, which the CPU control FSM uses to leave its memory-wait states.

Parameters:
- DEPTH, 256, number of 16-bit RAM words (power of two).
- WAIT_STATES, 2, idle cycles inserted between request acceptance and the response (0..15).
- IO_ADDR, 16'hFFFF, address decoded as the switch/hex I/O port.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Req  input  1  request strobe; sampled only in IDLE.
- WE  input  1  1 = write, 0 = read; sampled with Req.
- Addr  input  16  word address (MAR value); sampled with Req.
- Data_from_CPU  input  16  write data (MDR value); sampled with Req.
- Switches  input  16  board switch inputs.
- Data_to_CPU  output  16  read data; valid from the Ready cycle until the next Ready.
- Ready  output  1  one-cycle completion pulse for reads and writes.
- Busy  output  1  high while a request is in flight (WAIT or RESP).
- Hex_Out  output  16  hex display register.
- Overrun  output  1  sticky flag; set when Req arrives while Busy.

Behaviour:
- Reset (Reset=0, asynchronous):
  - FSM goes to IDLE; wait counter = 0.
  - Ready=0, Busy=0, Data_to_CPU=16'h0000, Hex_Out=16'h0000, Overrun=0.
  - RAM contents are not cleared.
- FSM states:
  - IDLE: on Req=1, latch WE, Addr and Data_from_CPU, load the counter with WAIT_STATES, and go to WAIT. If WAIT_STATES=0, go straight to RESP.
  - WAIT: decrement the counter each cycle. When the counter is 1, next state is RESP.
  - RESP: Ready=1 for exactly this cycle, then IDLE.
- Busy = (state != IDLE).
- Latency: Req sampled high at edge t gives Ready high in cycle t+1+WAIT_STATES. The next request can be accepted at the edge that ends RESP+1, i.e. back-to-back spacing is WAIT_STATES+2 cycles.
- Read, RAM address:
  - Data_to_CPU is loaded with RAM[Addr mod DEPTH] on the edge entering RESP.
  - Addresses of DEPTH and above alias on the low log2(DEPTH) bits.
- Read, IO_ADDR: Data_to_CPU is loaded with Switches, sampled on the edge entering RESP (not at request time).
- Write, RAM address:
  - RAM[Addr mod DEPTH] is written on the edge entering RESP.
  - Data_to_CPU is unchanged.
- Write, IO_ADDR:
  - Hex_Out is loaded with the latched data on the edge entering RESP.
  - RAM is untouched.
- IO_ADDR decode takes priority over RAM aliasing, so 16'hFFFF never touches RAM.
- Req while Busy:
  - Ignored; the latched request is not modified.
  - Overrun is set to 1 and stays set until reset.
- Req held high across IDLE re-entry is treated as a new request. The CPU must drop Req after one cycle.
- Reset mid-operation:
  - Any pending write (state WAIT) is discarded, and RAM and Hex_Out are not modified.
  - A write is committed only on the edge entering RESP.
- WE, Addr and Data_from_CPU changing after acceptance have no effect.

Test Plan:
- Reset: Reset=0 then 1 -> Data_to_CPU=0, Hex_Out=0, Ready=0, Busy=0, Overrun=0.
- Write then read, WAIT_STATES=2:
  - Req/WE=1, Addr=16'h0010, data=16'hBEEF at edge t -> Busy high at t+1, Ready pulse in cycle t+3, one cycle wide.
  - Read of Addr=16'h0010 -> Data_to_CPU=16'hBEEF with Ready.
- Aliasing: write 16'h1234 to Addr=16'h0105 (DEPTH=256), read Addr=16'h0005 -> Data_to_CPU=16'h1234.
- I/O port:
  - Switches=16'h00A5, read 16'hFFFF -> Data_to_CPU=16'h00A5.
  - Write 16'h0C3F to 16'hFFFF -> Hex_Out=16'h0C3F, and RAM[255] unchanged.
- Overrun: second Req during WAIT -> Overrun=1, first request completes with the original address and data, and only one Ready pulse.
- Reset mid-write: write 16'hAAAA to 16'h0020, assert Reset in the WAIT cycle, release, read 16'h0020 -> the previously stored value is returned, not 16'hAAAA.
- Zero wait states: WAIT_STATES=0 -> Ready in cycle t+1.
